// File: rtl/button_conditioner_if.sv
// Purpose : groups the push-button inputs and the conditioned outputs of button_conditioner.
// Latency : none (wiring only).
// Backpressure : none; the pulses are fire-and-forget and the consumer must sample every mclk.
// Signals:
//   pButton  [3:0] raw buttons: [0] units digit, [1] tens digit, [2] button3, [3] setampm
//   pMode          raw mode button
//   vButton  [3:0] single-mclk press pulses; [2:0] auto-repeat while held
//   clk_mode [1:0] 0 default, 1 set time, 2 set alarm, 3 set date
interface button_conditioner_if;
  logic [3:0] pButton;
  logic       pMode;
  logic [3:0] vButton;
  logic [1:0] clk_mode;

  // master drives the raw buttons and consumes the conditioned outputs
  modport master (
    output pButton,
    output pMode,
    input  vButton,
    input  clk_mode
  );

  // slave is the conditioner itself
  modport slave (
    input  pButton,
    input  pMode,
    output vButton,
    output clk_mode
  );
endinterface

// File: rtl/button_conditioner.sv
// Purpose : synchronise, debounce and edge-detect 5 raw buttons; auto-repeat on the digit
//           buttons; cycle the 2-bit clk_mode selector on each mode press.
// Latency : clean raw rise to press pulse (and clk_mode step) = DEB_CYCLES+2 mclk edges.
// Backpressure : none; outputs are one-mclk pulses and a level, never held off.
// Ports:
//   mclk   main clock
//   rst    asynchronous active-high reset; clears every flop and forces outputs to 0 at once
//   io_bus slave side of button_conditioner_if (pButton, pMode in; vButton, clk_mode out)
module button_conditioner #(
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8,
  parameter int CNT_W         = 32
) (
  input  logic                 mclk,
  input  logic                 rst,
  button_conditioner_if.slave  io_bus
);

  // Channel map: [3:0] = pButton[3:0], [4] = pMode.
  localparam int NCH  = 5;
  // Only the three digit channels ([2:0]) auto-repeat.
  localparam int NREP = 3;
  localparam int MODE_CH = 4;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam bit               REP_EN   = (REPEAT_DELAY != 0);
  // Guarded so a disabled repeat (REPEAT_DELAY=0) does not wrap to all-ones.
  localparam logic [CNT_W-1:0] DLY_LAST = REP_EN ? CNT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    M0 = 2'd0,   // default
    M1 = 2'd1,   // set time
    M2 = 2'd2,   // set alarm
    M3 = 2'd3    // set date
  } mode_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]   w_raw;
  logic [NCH-1:0]   r_s1;
  logic [NCH-1:0]   r_s2;
  logic [NCH-1:0]   r_db;
  logic [NCH-1:0]   r_db_d;
  logic [CNT_W-1:0] r_cnt [NCH];

  logic [NCH-1:0]   w_db_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [NCH];
  logic [NCH-1:0]   w_rise;

  logic [CNT_W-1:0] r_rcnt [NREP];
  logic [NREP-1:0]  r_rphase;          // 0: waiting out REPEAT_DELAY, 1: periodic
  logic [CNT_W-1:0] w_rcnt_nxt [NREP];
  logic [NREP-1:0]  w_rphase_nxt;
  logic [NREP-1:0]  w_rep_pulse;

  logic [3:0]       r_pulse;
  logic [3:0]       w_pulse_nxt;

  mode_t            r_mode;
  mode_t            w_mode_nxt;

  assign w_raw = {io_bus.pMode, io_bus.pButton};

  // ---------------------------------------------------------------------------
  // Debounce next-state: a differing synchronised level must be seen for
  // DEB_CYCLES consecutive edges; any return to the accepted level restarts.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_db_nxt[i]  = r_db[i];
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_db[i]) begin
        if (r_cnt[i] == DEB_LAST) begin
          w_db_nxt[i] = r_s2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press event: the accepted level has just turned 0->1. Detecting it one
  // edge after acceptance keeps the pulse a clean registered output.
  assign w_rise = r_db & ~r_db_d;

  // ---------------------------------------------------------------------------
  // Auto-repeat next-state for the digit channels.
  // rcnt restarts on the press edge; the first reload fires REPEAT_DELAY edges
  // after the press pulse, later ones every REPEAT_PERIOD edges. A channel whose
  // accepted level drops (now or on this edge) is cleared and cannot fire.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < NREP; j++) begin
      w_rep_pulse[j]  = 1'b0;
      w_rcnt_nxt[j]   = r_rcnt[j];
      w_rphase_nxt[j] = r_rphase[j];
      if (!REP_EN || !r_db[j] || !w_db_nxt[j] || w_rise[j]) begin
        w_rcnt_nxt[j]   = '0;
        w_rphase_nxt[j] = 1'b0;
      end else if (r_rcnt[j] == (r_rphase[j] ? PER_LAST : DLY_LAST)) begin
        w_rep_pulse[j]  = 1'b1;
        w_rcnt_nxt[j]   = '0;
        w_rphase_nxt[j] = 1'b1;
      end else begin
        w_rcnt_nxt[j]   = r_rcnt[j] + CNT_W'(1);
      end
    end
  end

  // setampm (channel 3) gets the press pulse only.
  always_comb begin
    w_pulse_nxt = '0;
    for (int k = 0; k < 4; k++) begin
      w_pulse_nxt[k] = w_rise[k];
    end
    w_pulse_nxt[NREP-1:0] = w_rise[NREP-1:0] | w_rep_pulse;
  end

  // ---------------------------------------------------------------------------
  // Synchroniser, debouncer, edge detect and pulse registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      r_pulse <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_db    <= w_db_nxt;
      r_db_d  <= r_db;
      r_pulse <= w_pulse_nxt;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_rphase <= '0;
      for (int j = 0; j < NREP; j++) begin
        r_rcnt[j] <= '0;
      end
    end else begin
      r_rphase <= w_rphase_nxt;
      for (int j = 0; j < NREP; j++) begin
        r_rcnt[j] <= w_rcnt_nxt[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: steps on the same edge a mode press pulse would be raised, so a
  // long hold advances exactly once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_mode <= M0;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_rise[MODE_CH]) begin
      case (r_mode)
        M0:      w_mode_nxt = M1;
        M1:      w_mode_nxt = M2;
        M2:      w_mode_nxt = M3;
        M3:      w_mode_nxt = M0;
        default: w_mode_nxt = M0;
      endcase
    end
  end

  assign io_bus.vButton  = r_pulse;
  assign io_bus.clk_mode = r_mode;

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose : directed self-checking bench for button_conditioner (DEB=4, DELAY=20, PERIOD=8).
// Latency : expected pulses are hand-placed at DEB_CYCLES+2 = 6 edges after the raw rise.
// Backpressure : not applicable; outputs are sampled 1 time unit after every rising edge.
module tb_button_conditioner;
  logic mclk;
  logic rst;
  int   n_vec;
  int   n_err;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEB_CYCLES   (4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8),
    .CNT_W        (32)
  ) dut (
    .mclk  (mclk),
    .rst   (rst),
    .io_bus(bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Advance to just after the next rising edge. Inputs changed here are first
  // sampled by the following edge; outputs read here belong to the edge just passed.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pButton = 4'hF;
    bus.pMode   = 1'b1;
    idle(8);
    n_vec++;
    if (bus.vButton !== 4'h0) begin
      n_err++;
      $display("FAIL reset_vbutton: got %h want 0", bus.vButton);
    end
    n_vec++;
    if (bus.clk_mode !== 2'd0) begin
      n_err++;
      $display("FAIL reset_clk_mode: got %0d want 0", bus.clk_mode);
    end
    bus.pButton = 4'h0;
    bus.pMode   = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(4);
  endtask

  // Clean 10-cycle press on units digit: one pulse at cycle 6, none on release.
  task automatic test_clean_press();
    logic [3:0] exp;
    bus.pButton = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      tick();
      exp = (c == 6) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (bus.vButton !== exp) begin
        n_err++;
        $display("FAIL clean_press c=%0d: got %b want %b", c, bus.vButton, exp);
      end
      if (c == 9) bus.pButton = 4'b0000;
    end
    idle(5);
  endtask

  // Tens digit bounces every 2 cycles for 12 cycles, then stays high from 12.
  task automatic test_bounce();
    logic [3:0] exp;
    bus.pButton = 4'b0010;
    for (int c = 0; c < 46; c++) begin
      tick();
      exp = (c == 18) ? 4'b0010 : 4'b0000;
      n_vec++;
      if (bus.vButton !== exp) begin
        n_err++;
        $display("FAIL bounce c=%0d: got %b want %b", c, bus.vButton, exp);
      end
      // after edge c, set the level edge c+1 will sample
      if (c < 11)       bus.pButton = (((c + 1) / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      else if (c < 30)  bus.pButton = 4'b0010;
      else              bus.pButton = 4'b0000;
    end
    idle(5);
  endtask

  // Button3 held 56 cycles: press, delayed repeat, periodic repeats, none after release.
  task automatic test_repeat();
    logic [3:0] exp;
    bus.pButton = 4'b0100;
    for (int c = 0; c < 76; c++) begin
      tick();
      exp = (c == 6 || c == 26 || c == 34 || c == 42 || c == 50 || c == 58) ? 4'b0100 : 4'b0000;
      n_vec++;
      if (bus.vButton !== exp) begin
        n_err++;
        $display("FAIL repeat c=%0d: got %b want %b", c, bus.vButton, exp);
      end
      if (c == 55) bus.pButton = 4'b0000;
    end
    idle(5);
  endtask

  // setampm held 60 cycles: single pulse, never repeats.
  task automatic test_no_repeat_ch3();
    logic [3:0] exp;
    bus.pButton = 4'b1000;
    for (int c = 0; c < 80; c++) begin
      tick();
      exp = (c == 6) ? 4'b1000 : 4'b0000;
      n_vec++;
      if (bus.vButton !== exp) begin
        n_err++;
        $display("FAIL setampm c=%0d: got %b want %b", c, bus.vButton, exp);
      end
      if (c == 59) bus.pButton = 4'b0000;
    end
    idle(5);
  endtask

  // Five mode presses (1,2,3,0,1), then one long hold that steps only once (->2).
  task automatic test_mode();
    logic [1:0] seq [6];
    logic [1:0] exp;
    int         len;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2;
    seq[3] = 2'd3; seq[4] = 2'd0; seq[5] = 2'd1;
    for (int p = 0; p < 6; p++) begin
      len = (p == 5) ? 60 : 10;
      bus.pMode = 1'b1;
      for (int c = 0; c < len + 14; c++) begin
        tick();
        exp = (c >= 6) ? seq[p] + 2'd1 : seq[p];
        n_vec++;
        if (bus.clk_mode !== exp) begin
          n_err++;
          $display("FAIL mode p=%0d c=%0d: got %0d want %0d", p, c, bus.clk_mode, exp);
        end
        n_vec++;
        if (bus.vButton !== 4'b0000) begin
          n_err++;
          $display("FAIL mode_vbutton p=%0d c=%0d: got %b want 0000", p, c, bus.vButton);
        end
        if (c == len - 1) bus.pMode = 1'b0;
      end
    end
  endtask

  // Units, tens and mode pressed together: both pulses in one cycle, mode 2->3.
  task automatic test_back_to_back();
    logic [3:0] exp_v;
    logic [1:0] exp_m;
    bus.pButton = 4'b0011;
    bus.pMode   = 1'b1;
    for (int c = 0; c < 26; c++) begin
      tick();
      exp_v = (c == 6) ? 4'b0011 : 4'b0000;
      exp_m = (c >= 6) ? 2'd3 : 2'd2;
      n_vec++;
      if (bus.vButton !== exp_v) begin
        n_err++;
        $display("FAIL simul_vbutton c=%0d: got %b want %b", c, bus.vButton, exp_v);
      end
      n_vec++;
      if (bus.clk_mode !== exp_m) begin
        n_err++;
        $display("FAIL simul_mode c=%0d: got %0d want %0d", c, bus.clk_mode, exp_m);
      end
      if (c == 9) begin
        bus.pButton = 4'b0000;
        bus.pMode   = 1'b0;
      end
    end
    idle(5);
  endtask

  // Units held; async reset at cycle 30 clears outputs at once; after release
  // of reset the held button is a fresh press with repeats resuming.
  task automatic test_reset_midop();
    logic [3:0] exp;
    bus.pButton = 4'b0001;
    for (int c = 0; c <= 30; c++) begin
      tick();
      exp = (c == 6 || c == 26) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (bus.vButton !== exp) begin
        n_err++;
        $display("FAIL prereset c=%0d: got %b want %b", c, bus.vButton, exp);
      end
    end
    n_vec++;
    if (bus.clk_mode !== 2'd3) begin
      n_err++;
      $display("FAIL prereset_mode: got %0d want 3", bus.clk_mode);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.clk_mode !== 2'd0) begin
      n_err++;
      $display("FAIL async_rst_mode: got %0d want 0", bus.clk_mode);
    end
    n_vec++;
    if (bus.vButton !== 4'b0000) begin
      n_err++;
      $display("FAIL async_rst_vbutton: got %b want 0000", bus.vButton);
    end
    idle(2);
    rst = 1'b0;
    for (int c = 0; c < 61; c++) begin
      tick();
      exp = (c == 6 || c == 26 || c == 34 || c == 42) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (bus.vButton !== exp) begin
        n_err++;
        $display("FAIL postreset c=%0d: got %b want %b", c, bus.vButton, exp);
      end
      if (c == 43) bus.pButton = 4'b0000;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.pButton = 4'h0;
    bus.pMode   = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_no_repeat_ch3();
    test_mode();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
